// File: rtl/pipe_collision.sv
// rtl/pipe_collision.sv - scrolling pipe obstacle, bird collision judge, score keeper
module pipe_collision #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int PIPE_WIDTH = 40,
    parameter int GAP_HEIGHT = 120,
    parameter int GAP_MIN    = 40,
    parameter int SCROLL     = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Tick,
    input  logic [9:0] Bird_X_L,
    input  logic [9:0] Bird_X_R,
    input  logic [9:0] Bird_Y_T,
    input  logic [9:0] Bird_Y_B,
    output logic [9:0] Pipe_X_L,
    output logic [9:0] Pipe_X_R,
    output logic [9:0] Gap_Y_T,
    output logic [9:0] Gap_Y_B,
    output logic       Stop,
    output logic [7:0] Score,
    output logic       q_Initial,
    output logic       q_Run,
    output logic       q_Over
);

    localparam logic [9:0] X_L_HOME = 10'(SCREEN_W);
    localparam logic [9:0] X_R_HOME = 10'(SCREEN_W + PIPE_WIDTH);
    localparam logic [9:0] GAP_HOME = 10'd180;
    localparam logic [9:0] GAP_H    = 10'(GAP_HEIGHT);
    localparam logic [9:0] GAP_LO   = 10'(GAP_MIN);
    localparam logic [9:0] SCR      = 10'(SCROLL);
    localparam logic [9:0] FLOOR    = 10'(SCREEN_H);

    typedef enum logic [2:0] {
        Q_INITIAL = 3'b001,
        Q_RUN     = 3'b010,
        Q_OVER    = 3'b100
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] x_l_q, x_l_d;
    logic [9:0] x_r_q, x_r_d;
    logic [9:0] gap_t_q, gap_t_d;
    logic [7:0] score_q, score_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       col;

    assign col = ((Bird_X_R > x_l_q) && (Bird_X_L < x_r_q) &&
                  ((Bird_Y_T < gap_t_q) || (Bird_Y_B > gap_t_q + GAP_H))) ||
                 (Bird_Y_B >= FLOOR);

    always_comb begin
        state_d = state_q;
        x_l_d   = x_l_q;
        x_r_d   = x_r_q;
        gap_t_d = gap_t_q;
        score_d = score_q;
        // x^8+x^6+x^5+x^4+1, free-running so each round sees a different gap sequence
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        case (state_q)
            Q_INITIAL: begin
                x_l_d   = X_L_HOME;
                x_r_d   = X_R_HOME;
                gap_t_d = GAP_HOME;
                score_d = 8'd0;
                if (Start) state_d = Q_RUN;
            end
            Q_RUN: begin
                if (col) begin
                    state_d = Q_OVER;
                end else if (Tick) begin
                    // scoring uses pre-move edges, so it still counts on a respawn Tick
                    if ((x_r_q >= Bird_X_L) && (x_r_q - SCR < Bird_X_L) && (score_q != 8'hFF))
                        score_d = score_q + 8'd1;
                    if (x_r_q <= SCR) begin
                        x_l_d   = X_L_HOME;
                        x_r_d   = X_R_HOME;
                        gap_t_d = GAP_LO + {2'b00, lfsr_q};
                    end else begin
                        x_r_d = x_r_q - SCR;
                        x_l_d = (x_l_q < SCR) ? 10'd0 : x_l_q - SCR;
                    end
                end
            end
            Q_OVER: begin
                if (Ack) begin
                    state_d = Q_INITIAL;
                    x_l_d   = X_L_HOME;
                    x_r_d   = X_R_HOME;
                    gap_t_d = GAP_HOME;
                    score_d = 8'd0;
                end
            end
            default: begin
                state_d = Q_INITIAL;
                x_l_d   = X_L_HOME;
                x_r_d   = X_R_HOME;
                gap_t_d = GAP_HOME;
                score_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= Q_INITIAL;
            x_l_q   <= X_L_HOME;
            x_r_q   <= X_R_HOME;
            gap_t_q <= GAP_HOME;
            score_q <= 8'd0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            x_l_q   <= x_l_d;
            x_r_q   <= x_r_d;
            gap_t_q <= gap_t_d;
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign Pipe_X_L  = x_l_q;
    assign Pipe_X_R  = x_r_q;
    assign Gap_Y_T   = gap_t_q;
    assign Gap_Y_B   = gap_t_q + GAP_H;
    assign Score     = score_q;
    assign q_Initial = state_q[0];
    assign q_Run     = state_q[1];
    assign q_Over    = state_q[2];
    assign Stop      = state_q[2];

endmodule

// File: tb/tb_pipe_collision.sv
// tb/tb_pipe_collision.sv - scoreboard bench for pipe_collision against a behavioural game model
module tb_pipe_collision;

    logic       Clk = 1'b0;
    logic       reset, Start, Ack, Tick;
    logic [9:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
    logic [9:0] Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B;
    logic       Stop, q_Initial, q_Run, q_Over;
    logic [7:0] Score;

    always #5 Clk = ~Clk;

    pipe_collision dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Tick(Tick),
        .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
        .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R), .Gap_Y_T(Gap_Y_T), .Gap_Y_B(Gap_Y_B),
        .Stop(Stop), .Score(Score), .q_Initial(q_Initial), .q_Run(q_Run), .q_Over(q_Over)
    );

    typedef struct packed {
        logic [9:0] xl;
        logic [9:0] xr;
        logic [9:0] gt;
        logic [9:0] gb;
        logic [7:0] score;
        logic       stop;
        logic       qi;
        logic       qr;
        logic       qo;
    } obs_t;

    obs_t exp_q[$];
    int total = 0;
    int bad   = 0;
    bit driver_done = 0;

    // game model: mode 0 = waiting, 1 = flying, 2 = game over
    int m_mode, m_xl, m_xr, m_gt, m_score, m_lfsr;

    function automatic int lfsr_next(int v);
        int taps[4] = '{8, 6, 5, 4};
        int fb = 0;
        foreach (taps[i]) fb ^= (v >> (taps[i] - 1)) & 1;
        return ((v << 1) | fb) & 255;
    endfunction

    task automatic model_home();
        m_xl = 640; m_xr = 680; m_gt = 180; m_score = 0;
    endtask

    task automatic model_step();
        int cur;
        bit hit;
        if (reset) begin
            m_mode = 0; model_home(); m_lfsr = 8'hA5;
        end else begin
            cur = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            if (m_mode == 0) begin
                model_home();
                if (Start) m_mode = 1;
            end else if (m_mode == 1) begin
                hit = (int'(Bird_X_R) > m_xl && int'(Bird_X_L) < m_xr &&
                       (int'(Bird_Y_T) < m_gt || int'(Bird_Y_B) > m_gt + 120)) ||
                      int'(Bird_Y_B) >= 480;
                if (hit) m_mode = 2;
                else if (Tick) begin
                    if (m_xr >= int'(Bird_X_L) && m_xr - 2 < int'(Bird_X_L) && m_score < 255)
                        m_score++;
                    if (m_xr <= 2) begin
                        m_xl = 640; m_xr = 680; m_gt = 40 + cur;
                    end else begin
                        m_xr -= 2;
                        m_xl = (m_xl < 2) ? 0 : m_xl - 2;
                    end
                end
            end else if (Ack) begin
                m_mode = 0; model_home();
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.xl = 10'(m_xl); o.xr = 10'(m_xr); o.gt = 10'(m_gt); o.gb = 10'(m_gt + 120);
        o.score = 8'(m_score);
        o.stop = (m_mode == 2); o.qi = (m_mode == 0); o.qr = (m_mode == 1); o.qo = (m_mode == 2);
        return o;
    endfunction

    task automatic cycle();
        model_step();
        exp_q.push_back(model_obs());
        @(negedge Clk);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic bird_in_gap(input int xl);
        Bird_X_L = 10'(xl); Bird_X_R = 10'(xl + 20);
        Bird_Y_T = 10'(m_gt + 40); Bird_Y_B = 10'(m_gt + 60);
    endtask

    // monitor: every cycle the DUT presents a full output set; compare with the oldest prediction
    always begin
        obs_t e, a;
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B, Score, Stop, q_Initial, q_Run, q_Over};
            total++;
            if (a !== e) begin
                bad++;
                if (bad <= 20)
                    $display("FAIL scoreboard t=%0t actual xl=%0d xr=%0d gt=%0d gb=%0d sc=%0d st=%b q=%b%b%b expected xl=%0d xr=%0d gt=%0d gb=%0d sc=%0d st=%b q=%b%b%b",
                             $time, a.xl, a.xr, a.gt, a.gb, a.score, a.stop, a.qo, a.qr, a.qi,
                             e.xl, e.xr, e.gt, e.gb, e.score, e.stop, e.qo, e.qr, e.qi);
            end
        end
    end

    initial begin
        int pre_xr;
        reset = 1; Start = 0; Ack = 0; Tick = 0;
        Bird_X_L = 0; Bird_X_R = 0; Bird_Y_T = 0; Bird_Y_B = 0;
        m_mode = 0; model_home(); m_lfsr = 8'hA5;

        // reset held two cycles then released
        cycle(); cycle();
        reset = 0; cycle();
        chk("init_q_initial", q_Initial, 1);
        chk("init_x_l", Pipe_X_L, 640);
        chk("init_x_r", Pipe_X_R, 680);
        chk("init_gap_t", Gap_Y_T, 180);
        chk("init_gap_b", Gap_Y_B, 300);
        chk("init_score", Score, 0);
        chk("init_stop", Stop, 0);

        // one pipe pass with the bird in the gap at x 300..320
        Start = 1; bird_in_gap(300); cycle(); Start = 0;
        repeat (330) begin Tick = 1; bird_in_gap(300); cycle(); end
        Tick = 0;
        chk("pass_score", Score, 1);
        chk("pass_stop", Stop, 0);
        chk("pass_x_r", Pipe_X_R, 20);

        // collision against the upper pipe at Pipe_X_L=310, then frozen under Ticks
        reset = 1; cycle(); reset = 0;
        Start = 1; bird_in_gap(100); cycle(); Start = 0;
        repeat (165) begin Tick = 1; bird_in_gap(100); cycle(); end
        Tick = 0;
        chk("pre_hit_x_l", Pipe_X_L, 310);
        Bird_X_L = 300; Bird_X_R = 320; Bird_Y_T = 100; Bird_Y_B = 120;
        cycle();
        chk("hit_stop", Stop, 1);
        chk("hit_q_over", q_Over, 1);
        Tick = 1; repeat (3) cycle(); Tick = 0;
        chk("over_frozen_x_l", Pipe_X_L, 310);
        Start = 1; cycle(); Start = 0;
        chk("over_ignores_start", q_Over, 1);
        Ack = 1; cycle(); Ack = 0;
        chk("ack_q_initial", q_Initial, 1);
        chk("ack_stop", Stop, 0);
        chk("ack_score", Score, 0);
        chk("ack_x_l", Pipe_X_L, 640);

        // floor hit coinciding with a Tick: no move, game over
        Start = 1; bird_in_gap(100); cycle(); Start = 0;
        Tick = 1; Bird_Y_T = 460; Bird_Y_B = 480; cycle(); Tick = 0;
        chk("floor_stop", Stop, 1);
        chk("floor_no_move", Pipe_X_L, 640);
        Ack = 1; cycle(); Ack = 0;

        // bird chases the pipe edge so every Tick scores; runs through a respawn
        Start = 1; bird_in_gap(100); cycle(); Start = 0;
        repeat (400) begin
            pre_xr = m_xr;
            Tick = 1; bird_in_gap(m_xr); Bird_X_R = Bird_X_L;
            cycle();
            if (pre_xr == 2) begin
                chk("respawn_x_l", Pipe_X_L, 640);
                chk("respawn_x_r", Pipe_X_R, 680);
                chk("respawn_gap_in_range", (Gap_Y_T >= 40 && Gap_Y_T <= 295), 1);
            end
        end
        Tick = 0;
        chk("score_saturated", Score, 255);
        chk("sat_run", q_Run, 1);

        // reset in the middle of a round
        reset = 1; cycle(); reset = 0;
        chk("midreset_q_initial", q_Initial, 1);
        chk("midreset_score", Score, 0);
        chk("midreset_x_r", Pipe_X_R, 680);
        chk("midreset_gap_t", Gap_Y_T, 180);

        // randomized play
        repeat (3000) begin
            reset = ($urandom_range(0, 399) == 0);
            Start = ($urandom_range(0, 7) == 0);
            Ack   = ($urandom_range(0, 7) == 0);
            Tick  = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                bird_in_gap(m_xr); Bird_X_R = Bird_X_L;
            end else begin
                bird_in_gap($urandom_range(0, 620));
            end
            if ($urandom_range(0, 15) == 0) begin
                Bird_Y_T = 10'($urandom_range(0, 480));
                Bird_Y_B = Bird_Y_T + 10'($urandom_range(0, 20));
            end
            cycle();
        end
        reset = 0; Start = 0; Ack = 0; Tick = 0;

        @(negedge Clk);
        driver_done = 1;
    end

    initial begin
        int waited = 0;
        while (!driver_done && waited < 20000) begin
            @(negedge Clk);
            waited++;
        end
        if (!driver_done) begin
            total++; bad++;
            $display("FAIL driver_timeout actual=%0d expected=%0d", waited, 20000);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
